// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: PC/latch enables and flushes for cache stalls, load-use, redirects and halt drain.
// Optional build macro HAZARD_PERF_EN adds saturating stall/bubble/flush performance counters.
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halt
);

    // A zero-length drain still needs a one-bit counter to stay legal.
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          halt_q;
    logic          memwait, lduse;

    assign memwait = (mem_dREN | mem_dWEN) & ~dhit;
    assign lduse   = ex_dREN & (ex_wsel != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_wsel)) | (id_uses_rt & (id_rt == ex_wsel)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (memwait) begin
                    // whole pipeline frozen; a pending halt is re-seen next cycle
                end else if (ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lduse) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    if (!ihit) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                    if (id_halt) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                idex_flush = 1'b1;
                idex_en    = ~memwait;
                exmem_en   = ~memwait;
                memwb_en   = ~memwait;
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else if (!memwait) begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            ST_HALTED: begin
            end
            default: state_d = ST_RUN;
        endcase
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= (state_d == ST_HALTED);
        end
    end

    assign halt = halt_q & ~RST;

`ifdef HAZARD_PERF_EN
    logic [2:0]       perf_ev;
    logic [CNT_W-1:0] perf_q [3];

    // Events mirror the RUN priority chain: stall, then flush, then bubble.
    assign perf_ev[0] = (state_q == ST_RUN) & memwait;
    assign perf_ev[1] = (state_q == ST_RUN) & ~memwait & ~ex_redirect & (lduse | ~ihit);
    assign perf_ev[2] = (state_q == ST_RUN) & ~memwait & ex_redirect;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge CLK) begin
                if (RST) begin
                    perf_q[gi] <= '0;
                end else if (perf_ev[gi] && (perf_q[gi] != {CNT_W{1'b1}})) begin
                    perf_q[gi] <= perf_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt  = perf_q[0];
    assign bubble_cnt = perf_q[1];
    assign flush_cnt  = perf_q[2];
`endif

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencing controller for the five-stage core. It generates every PC enable, pipeline-latch enable and latch flush, covering these cases:
- instruction-cache misses
- data-cache waits
- load-use hazards
- taken branches and jumps
- halt drain

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB latches and is the single source of their enable/flush controls.

## Interface
Parameters:
- DRAIN_CYCLES, default 3: un-frozen cycles that elapse after a halt is decoded before `halt` asserts. This lets EX, MEM and WB retire.
- CNT_W, default 32: width of performance counters (see Configuration).

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction cache delivered the fetched word this cycle.
- dhit  in  1  data cache completed the MEM-stage access this cycle.
- mem_dREN, mem_dWEN  in  1 each  MEM stage holds a load/store.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs/rt.
- id_halt  in  1  ID holds a halt opcode (6'b111111).
- ex_dREN  in  1  EX holds a load.
- ex_wsel  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch or jump; PC is being redirected.
- pc_en  out  1  PC register update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch capture enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (all-zero) into latch.
- halt  out  1  core halted; sticky.

## Operation
States are RUN, DRAIN and HALTED.

Condition terms:
- memwait = (mem_dREN | mem_dWEN) & ~dhit
- lduse = ex_dREN & (ex_wsel != 0) & ((id_uses_rs & id_rs == ex_wsel) | (id_uses_rt & id_rt == ex_wsel))

Outputs in RUN are evaluated in strict priority order; the first match wins.
1. memwait: all enables 0, all flushes 0. The whole pipeline freezes.
2. ex_redirect:
   - pc_en=1; idex_en, exmem_en, memwb_en = 1.
   - ifid_flush=1, idex_flush=1. This squashes the two wrong-path instructions.
   - id_halt is ignored this cycle.
3. lduse:
   - pc_en=0, ifid_en=0: PC and IF/ID hold.
   - idex_flush=1 inserts one bubble; exmem_en=memwb_en=1.
4. ~ihit:
   - pc_en=0, ifid_en=0.
   - idex_flush=1, so ID/EX receives a bubble; downstream latches are enabled.
5. Otherwise: all enables 1, all flushes 0.

Halt handling:
- id_halt in RUN, under rule 4 or 5, moves the FSM to DRAIN and loads the drain counter with DRAIN_CYCLES.
- id_halt under rules 1 or 3 does not transition; it is re-evaluated next cycle.

DRAIN state:
- pc_en=0, ifid_en=0, idex_flush=1.
- exmem_en and memwb_en follow memwait: both 0 if memwait, else 1.
- The counter decrements only on cycles where memwait=0.
- When the counter reaches 0, the FSM enters HALTED.
- ex_redirect in DRAIN is ignored. The halt is younger than any EX instruction, so a redirect cannot occur.

HALTED state:
- All enables 0, all flushes 0, halt=1.
- The FSM stays in HALTED until RST.

## Timing
- All outputs except halt are combinational from state and inputs; zero-cycle latency.
- halt is registered: it rises on the edge that enters HALTED.
- Reset: on the edge with RST=1, the FSM goes to RUN, the counter to 0 and halt to 0.
  - While RST is high, outputs are forced to: all enables 0, ifid_flush, idex_flush and exmem_flush = 1, halt=0.
  - Reset asserted mid-DRAIN or in HALTED returns the FSM to RUN on that edge.
- Load-use always costs exactly one bubble: the next cycle EX holds the bubble, so lduse clears.
- With DRAIN_CYCLES=3 and no memwait, halt=1 occurs 4 edges after the edge that latched id_halt into DRAIN.
- memwait and ex_redirect together: memwait wins, and the redirect is serviced on the first cycle after dhit.
- Drain counter width is $clog2(DRAIN_CYCLES+1).
- DRAIN_CYCLES=0 gives a direct DRAIN→HALTED on the next edge.

## Configuration
- HAZARD_PERF_EN defined: adds three CNT_W-bit saturating counters. Each increments once per qualifying cycle in RUN and is cleared by RST.
  - stall_cnt counts memwait cycles.
  - bubble_cnt counts cycles where lduse or ~ihit inserts a bubble.
  - flush_cnt counts ex_redirect cycles.
  - Each counter is exposed as an output port of the same name.
- HAZARD_PERF_EN undefined: these counters and ports do not exist. Control behaviour is identical in both builds.

## Test plan
- Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, id_uses_rs=1, ihit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. The next cycle (ex_dREN=0) shows all enables 1.
- Zero register: ex_dREN=1, ex_wsel=0, id_rs=0 → no stall.
- D-cache wait: mem_dREN=1, dhit=0 for 4 cycles → all enables 0 for 4 cycles, no flushes. On the cycle with dhit=1, normal flow resumes.
- Redirect versus load-use in the same cycle: ex_redirect=1 and lduse true → pc_en=1, ifid_flush=1, idex_flush=1.
- Halt drain: id_halt=1, ihit=1, DRAIN_CYCLES=3, with one memwait cycle during DRAIN → halt rises 5 edges after entry. Afterwards all enables remain 0 until RST.
- Reset mid-DRAIN: RST=1 for one edge at counter=2 → state RUN, halt=0. With HAZARD_PERF_EN defined, all counters read 0.
